rect_plotter: RTL and testbench



---
 rtl/rect_plotter.sv | 172 +++++++++++++++++
 tb/tb_rect_plotter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// Rectangle / full-screen clear engine feeding the 160x120 VGA adapter pixel-write port.
// Emits one registered candidate pixel per clock; first pixel one edge after command accept, no backpressure.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int DIM_W    = 5,
  parameter int COL_W    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [DIM_W-1:0] w_in,
  input  logic [DIM_W-1:0] h_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             fill,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  typedef enum logic [1:0] {IDLE, CLEAR, RECT, DONE} state_t;

  localparam logic [X_W-1:0] LAST_CX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] LAST_CY = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   LIM_X   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   LIM_Y   = (Y_W+1)'(SCREEN_H);

  state_t state_q, state_d;

  logic [X_W-1:0]   x0_q, x0_d, dx_q, dx_d;
  logic [Y_W-1:0]   y0_q, y0_d, dy_q, dy_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             fill_q, fill_d;

  logic             busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;

  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic         last_x, last_y, edge_px, on_screen;

  // Sums carry one extra bit so off-screen pixels are clipped rather than wrapped.
  assign sum_x     = {1'b0, x0_q} + {1'b0, dx_q};
  assign sum_y     = {1'b0, y0_q} + {1'b0, dy_q};
  assign on_screen = (sum_x < LIM_X) && (sum_y < LIM_Y);
  assign last_x    = (state_q == CLEAR) ? (dx_q == LAST_CX) : ((dx_q + X_W'(1)) == X_W'(w_q));
  assign last_y    = (state_q == CLEAR) ? (dy_q == LAST_CY) : ((dy_q + Y_W'(1)) == Y_W'(h_q));
  assign edge_px   = (dx_q == '0) || last_x || (dy_q == '0) || last_y;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    fill_d   = fill_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    plot_d   = 1'b0;
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          // A clear is a full-screen filled scan anchored at the origin.
          col_d   = colour_in;
          x0_d    = '0;
          y0_d    = '0;
          fill_d  = 1'b1;
          dx_d    = '0;
          dy_d    = '0;
          state_d = CLEAR;
        end else if (start) begin
          x0_d    = x_in;
          y0_d    = y_in;
          w_d     = w_in;
          h_d     = h_in;
          col_d   = colour_in;
          fill_d  = fill;
          dx_d    = '0;
          dy_d    = '0;
          state_d = ((w_in == '0) || (h_in == '0)) ? DONE : RECT;
        end
      end

      CLEAR, RECT: begin
        busy_d   = 1'b1;
        x_d      = sum_x[X_W-1:0];
        y_d      = sum_y[Y_W-1:0];
        colour_d = col_q;
        plot_d   = on_screen && (fill_q || edge_px);
        if (last_x) begin
          dx_d = '0;
          if (last_y) begin
            state_d = DONE;
          end else begin
            dy_d = dy_q + Y_W'(1);
          end
        end else begin
          dx_d = dx_q + X_W'(1);
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      fill_q   <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      fill_q   <= fill_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: reset, filled/outline/clipped rectangles, clear, zero-size command.
module tb_rect_plotter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [4:0] w_in = '0;
  logic [4:0] h_in = '0;
  logic [2:0] colour_in = '0;
  logic       fill = 1'b0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  rect_plotter dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
    .colour_in(colour_in), .fill(fill),
    .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic cl, input logic st, input int xi, input int yi,
                       input int wi, input int hi, input logic [2:0] ci, input logic fi);
    clear     = cl;
    start     = st;
    x_in      = 8'(xi);
    y_in      = 7'(yi);
    w_in      = 5'(wi);
    h_in      = 5'(hi);
    colour_in = ci;
    fill      = fi;
    step();
    start = 1'b0;
    clear = 1'b0;
  endtask

  int nplot, nbusy, done_at, busy_at_done;
  int fx, fy, lx, ly, col_err, wrap_err, order_err;
  int holes[$];

  // Observes one command cycle by cycle until done, optionally pulsing start at cycle inj.
  task automatic watch(input int limit, input int inj, input logic [2:0] ecol, input logic is_clear);
    nplot = 0; nbusy = 0; done_at = -1; busy_at_done = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    col_err = 0; wrap_err = 0; order_err = 0;
    holes.delete();
    for (int i = 1; i <= limit; i++) begin
      start = (i == inj);
      step();
      if (plot) begin
        if (nplot == 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        if (colour != ecol) col_err++;
        if (x >= 8'd160 || y >= 7'd120) wrap_err++;
        if (is_clear && (int'(x) != nplot % 160 || int'(y) != nplot / 160)) order_err++;
        nplot++;
      end else if (busy) begin
        holes.push_back(int'(x) * 256 + int'(y));
      end
      if (busy) nbusy++;
      if (done) begin
        done_at = i;
        busy_at_done = int'(busy);
        break;
      end
    end
    start = 1'b0;
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  int cnt;

  initial begin
    // Reset state
    step();
    step();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();

    // Reset in the middle of a clear
    issue(1'b1, 1'b0, 0, 0, 0, 0, 3'b110, 1'b0);
    repeat (50) step();
    check("midclr_x", x, 49);
    check("midclr_plot", plot, 1);
    check("midclr_colour", colour, 3'b110);
    reset = 1'b0;
    step();
    check("abort_outputs", {x, y, colour, plot, busy, done}, 0);
    reset = 1'b1;
    cnt = 0;
    repeat (5) begin step(); cnt += int'(done) + int'(busy); end
    check("abort_no_done", cnt, 0);

    // Filled 4x4 square
    issue(1'b0, 1'b1, 10, 20, 4, 4, 3'b100, 1'b1);
    watch(100, -1, 3'b100, 1'b0);
    check("sq_plots", nplot, 16);
    check("sq_busy", nbusy, 16);
    check("sq_done_at", done_at, 17);
    check("sq_busy_at_done", busy_at_done, 0);
    check("sq_first_x", fx, 10);
    check("sq_first_y", fy, 20);
    check("sq_last_x", lx, 13);
    check("sq_last_y", ly, 23);
    check("sq_colour", col_err, 0);
    step();
    check("sq_done_width", done, 0);

    // Outline 5x3
    issue(1'b0, 1'b1, 0, 0, 5, 3, 3'b010, 1'b0);
    watch(100, -1, 3'b010, 1'b0);
    check("ol_plots", nplot, 12);
    check("ol_busy", nbusy, 15);
    check("ol_done_at", done_at, 16);
    check("ol_holes", holes.size(), 3);
    if (holes.size() == 3) begin
      check("ol_hole0", holes[0], 1 * 256 + 1);
      check("ol_hole1", holes[1], 2 * 256 + 1);
      check("ol_hole2", holes[2], 3 * 256 + 1);
    end

    // Clipping at the bottom-right corner
    issue(1'b0, 1'b1, 158, 118, 4, 4, 3'b111, 1'b1);
    watch(100, -1, 3'b111, 1'b0);
    check("clip_plots", nplot, 4);
    check("clip_busy", nbusy, 16);
    check("clip_done_at", done_at, 17);
    check("clip_wrapped", wrap_err, 0);
    check("clip_first_x", fx, 158);
    check("clip_first_y", fy, 118);
    check("clip_last_x", lx, 159);
    check("clip_last_y", ly, 119);

    // start+clear together: clear wins; a start during the clear is ignored
    issue(1'b1, 1'b1, 5, 5, 1, 1, 3'b001, 1'b1);
    watch(20000, 100, 3'b001, 1'b1);
    check("clr_plots", nplot, 19200);
    check("clr_busy", nbusy, 19200);
    check("clr_done_at", done_at, 19201);
    check("clr_order", order_err, 0);
    check("clr_colour", col_err, 0);
    check("clr_first", fx * 256 + fy, 0);
    check("clr_last", lx * 256 + ly, 159 * 256 + 119);
    cnt = 0;
    repeat (10) begin step(); cnt += int'(done) + int'(busy) + int'(plot); end
    check("clr_single_done", cnt, 0);

    // Zero-width command
    issue(1'b0, 1'b1, 20, 20, 0, 5, 3'b011, 1'b1);
    watch(10, -1, 3'b011, 1'b0);
    check("zero_done_at", done_at, 1);
    check("zero_plots", nplot, 0);
    check("zero_busy", nbusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
